// File: rtl/record_pkg.sv
// Shared definitions for the parsed-record path: record/word geometry and serializer FSM states.
package record_pkg;

    localparam int REC_W  = 296;
    localparam int WORD_W = 32;
    localparam int NWORDS = (REC_W + WORD_W - 1) / WORD_W;
    localparam int CNT_W  = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/record_fifo.sv
// Small circular record buffer; only the pointers and occupancy are reset, the storage is not.
module record_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = record_pkg::REC_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [0:WIDTH-1]           din,
    output logic [0:WIDTH-1]           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_B = $clog2(DEPTH + 1);

    logic [0:WIDTH-1] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPush;
    logic             doPop;

    assign doPush = push && !full;
    assign doPop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + CNT_B'(1);
                2'b01:   count <= count - CNT_B'(1);
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == CNT_B'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rdPtr];

endmodule

// File: rtl/record_serializer.sv
// Buffers parsed records and emits each one as a stream of egress words with a last flag,
// plus saturating status counters for emitted records and parser packet losses.
module record_serializer #(
    parameter int REC_W  = record_pkg::REC_W,
    parameter int WORD_W = record_pkg::WORD_W,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = record_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [0:REC_W-1]  rec_in,
    input  logic              rec_in_val,
    output logic              rec_in_ready,
    input  logic              pkt_lost_in,
    output logic [WORD_W-1:0] word_out,
    output logic              word_out_val,
    input  logic              word_out_ready,
    output logic              word_out_last,
    output logic [CNT_W-1:0]  rec_count,
    output logic [CNT_W-1:0]  lost_count
);

    localparam int NWORDS = (REC_W + WORD_W - 1) / WORD_W;
    localparam int PAD_W  = NWORDS * WORD_W;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int FCNT_W = $clog2(DEPTH + 1);

    record_pkg::state_t state;
    logic [IDX_W-1:0]   wordIdx;
    logic [0:REC_W-1]   head;
    logic [FCNT_W-1:0]  fifoCount;
    logic               fifoFull;
    logic               fifoEmpty;
    logic               pushReq;
    logic               outHs;
    logic               lastHs;
    logic [0:PAD_W-1]   padded;
    logic [WORD_W-1:0]  slice;
    logic [CNT_W-1:0]   recCnt;
    logic [CNT_W-1:0]   lostCnt;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Ready comes from registered occupancy only, so a pop frees the slot one cycle later.
    assign rec_in_ready = !fifoFull;
    assign pushReq      = rec_in_val && rec_in_ready;
    assign outHs        = word_out_val && word_out_ready;
    assign lastHs       = outHs && word_out_last;

    record_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) uFifo (
        .clk   (clk),
        .reset (reset),
        .push  (pushReq),
        .pop   (lastHs),
        .din   (rec_in),
        .head  (head),
        .count (fifoCount),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

    // Record bit 0 lands in the MSB of word 0; the tail of the final word is zero-filled.
    always_comb begin
        padded            = '0;
        padded[0:REC_W-1] = head;
        slice             = '0;
        for (int k = 0; k < NWORDS; k++) begin
            if (wordIdx == IDX_W'(k)) begin
                slice = padded[k*WORD_W +: WORD_W];
            end
        end
    end

    assign word_out_val  = (state == record_pkg::SEND);
    assign word_out_last = word_out_val && (wordIdx == IDX_W'(NWORDS - 1));
    assign word_out      = word_out_val ? slice : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= record_pkg::IDLE;
            wordIdx <= '0;
        end else begin
            case (state)
                record_pkg::IDLE: begin
                    if (!fifoEmpty) begin
                        state   <= record_pkg::SEND;
                        wordIdx <= '0;
                    end
                end
                record_pkg::SEND: begin
                    if (lastHs) begin
                        wordIdx <= '0;
                        // Keep streaming if another record remains after this pop.
                        if ((fifoCount == FCNT_W'(1)) && !pushReq) begin
                            state <= record_pkg::IDLE;
                        end
                    end else if (outHs) begin
                        wordIdx <= wordIdx + IDX_W'(1);
                    end
                end
                default: begin
                    state   <= record_pkg::IDLE;
                    wordIdx <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            recCnt  <= '0;
            lostCnt <= '0;
        end else begin
            if (lastHs) begin
                recCnt <= satInc(recCnt);
            end
            if (pkt_lost_in) begin
                lostCnt <= satInc(lostCnt);
            end
        end
    end

    assign rec_count  = recCnt;
    assign lost_count = lostCnt;

endmodule

// File: tb/tb_record_serializer.sv
// Directed bench for record_serializer: latency, back-to-back, backpressure, wrap, counters, reset.
module tb_record_serializer;
    import record_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic [0:REC_W-1]   rec_in;
    logic               rec_in_val;
    logic               rec_in_ready;
    logic               pkt_lost_in;
    logic [WORD_W-1:0]  word_out;
    logic               word_out_val;
    logic               word_out_ready;
    logic               word_out_last;
    logic [CNT_W-1:0]   rec_count;
    logic [CNT_W-1:0]   lost_count;

    int checks = 0;
    int errors = 0;

    record_serializer #(
        .REC_W  (REC_W),
        .WORD_W (WORD_W),
        .DEPTH  (2),
        .CNT_W  (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .rec_in         (rec_in),
        .rec_in_val     (rec_in_val),
        .rec_in_ready   (rec_in_ready),
        .pkt_lost_in    (pkt_lost_in),
        .word_out       (word_out),
        .word_out_val   (word_out_val),
        .word_out_ready (word_out_ready),
        .word_out_last  (word_out_last),
        .rec_count      (rec_count),
        .lost_count     (lost_count)
    );

    always #10 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] recByte(input int seed, input int i);
        return 8'((seed * 37 + i + 1) & 255);
    endfunction

    function automatic logic [0:REC_W-1] makeRec(input int seed);
        logic [0:REC_W-1] r;
        r = '0;
        for (int i = 0; i < REC_W / 8; i++) r[i*8 +: 8] = recByte(seed, i);
        return r;
    endfunction

    function automatic logic [31:0] expWord(input int seed, input int k);
        logic [31:0] w;
        w = '0;
        for (int b = 0; b < 4; b++)
            if (4 * k + b < REC_W / 8) w[31-8*b -: 8] = recByte(seed, 4 * k + b);
        return w;
    endfunction

    // Word monitor: snapshot outputs at negedge, decide the handshake at the following posedge.
    logic [WORD_W-1:0] gotW[$];
    logic              gotL[$];
    int                gotCyc[$];
    int                cyc = 0;
    logic              stallPend = 1'b0;
    logic [WORD_W-1:0] stallW;
    logic              stallL;
    logic              sv;
    logic              sl;
    logic [WORD_W-1:0] sw;
    bit                bpDone;

    always begin
        @(negedge clk);
        sv = word_out_val;
        sw = word_out;
        sl = word_out_last;
        if (stallPend) begin
            checkVal("stall_val", 64'(sv), 64'd1);
            checkVal("stall_word", 64'(sw), 64'(stallW));
            checkVal("stall_last", 64'(sl), 64'(stallL));
        end
        @(posedge clk);
        cyc++;
        if (sv && word_out_ready && !reset) begin
            gotW.push_back(sw);
            gotL.push_back(sl);
            gotCyc.push_back(cyc);
        end
        stallPend = sv && !word_out_ready && !reset;
        stallW    = sw;
        stallL    = sl;
    end

    task automatic clearMon();
        gotW.delete();
        gotL.delete();
        gotCyc.delete();
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic pushRec(input logic [0:REC_W-1] r);
        int n;
        n = 0;
        rec_in     = r;
        rec_in_val = 1'b1;
        while (!rec_in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) checkVal("push_timeout", 64'd0, 64'd1);
        @(negedge clk);
        rec_in_val = 1'b0;
    endtask

    task automatic waitWords(input int n, input string tag);
        int t;
        t = 0;
        while (gotW.size() < n && t < 1000) begin
            @(negedge clk);
            t++;
        end
        checkVal(tag, 64'(gotW.size()), 64'(n));
    endtask

    task automatic lostPulse(input int len);
        pkt_lost_in = 1'b1;
        repeat (len) @(negedge clk);
        pkt_lost_in = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int gaps;
        reset          = 1'b1;
        rec_in         = '0;
        rec_in_val     = 1'b0;
        pkt_lost_in    = 1'b0;
        word_out_ready = 1'b0;
        bpDone         = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkVal("rst_in_ready", 64'(rec_in_ready), 64'd1);
        checkVal("rst_out_val", 64'(word_out_val), 64'd0);
        checkVal("rst_out_last", 64'(word_out_last), 64'd0);
        checkVal("rst_word", 64'(word_out), 64'd0);
        checkVal("rst_rec_count", 64'(rec_count), 64'd0);
        checkVal("rst_lost_count", 64'(lost_count), 64'd0);

        // Single record, byte i = i+1
        word_out_ready = 1'b1;
        clearMon();
        pushRec(makeRec(0));
        checkVal("lat_idle_val", 64'(word_out_val), 64'd0);
        @(negedge clk);
        checkVal("lat_word0_val", 64'(word_out_val), 64'd1);
        checkVal("lat_word0", 64'(word_out), 64'h0102_0304);
        waitWords(10, "single_words");
        checkVal("single_w9", 64'(gotW[9]), 64'h2500_0000);
        checkVal("single_last9", 64'(gotL[9]), 64'd1);
        checkVal("single_last0", 64'(gotL[0]), 64'd0);
        for (int k = 0; k < 10; k++)
            checkVal($sformatf("single_w%0d", k), 64'(gotW[k]), 64'(expWord(0, k)));
        checkVal("single_rec_count", 64'(rec_count), 64'd1);
        checkVal("single_idle", 64'(word_out_val), 64'd0);

        // Back-to-back: three records into a two-deep FIFO
        clearMon();
        pushRec(makeRec(1));
        pushRec(makeRec(2));
        checkVal("b2b_full_ready", 64'(rec_in_ready), 64'd0);
        pushRec(makeRec(3));
        waitWords(30, "b2b_words");
        gaps = 0;
        for (int i = 1; i < gotCyc.size(); i++)
            if (gotCyc[i] != gotCyc[i-1] + 1) gaps++;
        checkVal("b2b_gaps", 64'(gaps), 64'd0);
        for (int i = 0; i < 30; i++)
            checkVal($sformatf("b2b_w%0d", i), 64'({gotL[i], gotW[i]}),
                     64'({(i % 10 == 9), expWord(1 + i / 10, i % 10)}));
        checkVal("b2b_rec_count", 64'(rec_count), 64'd4);

        // Backpressure: ready toggles every 15 time units against the 20-unit clock
        clearMon();
        bpDone = 1'b0;
        fork
            begin
                #2;
                while (!bpDone) begin
                    word_out_ready = ~word_out_ready;
                    #15;
                end
            end
            begin
                pushRec(makeRec(4));
                pushRec(makeRec(5));
                pushRec(makeRec(6));
                waitWords(30, "bp_words");
                bpDone = 1'b1;
            end
        join
        @(negedge clk);
        word_out_ready = 1'b1;
        for (int i = 0; i < 30; i++)
            checkVal($sformatf("bp_w%0d", i), 64'({gotL[i], gotW[i]}),
                     64'({(i % 10 == 9), expWord(4 + i / 10, i % 10)}));

        // Wrap: each new record is pushed in the same cycle as the previous last-word pop
        @(negedge clk);
        clearMon();
        pushRec(makeRec(10));
        for (int i = 1; i < 8; i++) begin
            t = 0;
            while (!(word_out_val && word_out_last) && t < 100) begin
                @(negedge clk);
                t++;
            end
            pushRec(makeRec(10 + i));
            checkVal($sformatf("wrap_count%0d", i), 64'(dut.uFifo.count), 64'd1);
            checkVal($sformatf("wrap_ready%0d", i), 64'(rec_in_ready), 64'd1);
            checkVal($sformatf("wrap_val%0d", i), 64'(word_out_val), 64'd1);
        end
        waitWords(80, "wrap_words");
        for (int i = 0; i < 80; i++)
            checkVal($sformatf("wrap_w%0d", i), 64'({gotL[i], gotW[i]}),
                     64'({(i % 10 == 9), expWord(10 + i / 10, i % 10)}));
        gaps = 0;
        for (int i = 1; i < gotCyc.size(); i++)
            if (gotCyc[i] != gotCyc[i-1] + 1) gaps++;
        checkVal("wrap_gaps", 64'(gaps), 64'd0);

        // Lost-packet counter and saturation
        repeat (5) lostPulse(1);
        checkVal("lost_5", 64'(lost_count), 64'd5);
        lostPulse(2);
        checkVal("lost_7", 64'(lost_count), 64'd7);
        force dut.lostCnt = 16'hFFFF;
        @(negedge clk);
        release dut.lostCnt;
        @(negedge clk);
        checkVal("lost_preload", 64'(lost_count), 64'hFFFF);
        repeat (3) lostPulse(1);
        checkVal("lost_sat", 64'(lost_count), 64'hFFFF);

        // Reset in the middle of a record with a second record queued
        clearMon();
        pushRec(makeRec(20));
        pushRec(makeRec(21));
        waitWords(5, "rst_pre_words");
        reset = 1'b1;
        #1;
        checkVal("rst_mid_val", 64'(word_out_val), 64'd0);
        checkVal("rst_mid_last", 64'(word_out_last), 64'd0);
        checkVal("rst_mid_rec_count", 64'(rec_count), 64'd0);
        checkVal("rst_mid_lost_count", 64'(lost_count), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkVal("rst_post_ready", 64'(rec_in_ready), 64'd1);
        checkVal("rst_post_val", 64'(word_out_val), 64'd0);
        clearMon();
        pushRec(makeRec(22));
        waitWords(10, "rst_new_words");
        for (int i = 0; i < 10; i++)
            checkVal($sformatf("rst_new_w%0d", i), 64'({gotL[i], gotW[i]}),
                     64'({(i == 9), expWord(22, i)}));
        repeat (5) @(negedge clk);
        checkVal("rst_no_stale", 64'(gotW.size()), 64'd10);
        checkVal("rst_new_rec_count", 64'(rec_count), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
